// File: rtl/cen_pkg.sv
// Shared constants and FSM state type for the centering accumulator.
// Optional CEN_ACC_SAT_EN switches lanes to saturating adds.
package cen_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SUM_W_DEF  = 40;
  localparam int N_LOG2_DEF = 7;
  localparam int FRAME_LEN  = 1 << N_LOG2_DEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PRESENT,
    FINISH
  } state_t;

endpackage

// File: rtl/cen_acc_lane.sv
// One channel of the centering accumulator: clearable running sum.
// Under CEN_ACC_SAT_EN the add saturates and flags it via sat.
module cen_acc_lane
  import cen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] x,
`ifdef CEN_ACC_SAT_EN
  output logic              sat,
`endif
  output logic [SUM_W-1:0]  sum
);

  logic [SUM_W-1:0] xe;
  logic [SUM_W-1:0] nxt;

  assign xe = SUM_W'(x);

`ifdef CEN_ACC_SAT_EN
  logic [SUM_W:0] wide;
  assign wide = {1'b0, sum} + {1'b0, xe};
  assign sat  = add_en & wide[SUM_W];
  assign nxt  = wide[SUM_W] ? '1 : wide[SUM_W-1:0];
`else
  assign nxt = sum + xe;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum <= '0;
    else if (clr)    sum <= '0;
    else if (add_en) sum <= nxt;
  end

endmodule

// File: rtl/cen_accumulator.sv
// Frame accumulator feeding the centering divider (four channels).
// Optional CEN_ACC_SAT_EN adds saturation and the sticky ovf output.
module cen_accumulator
  import cen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  input  logic [DATA_W-1:0] x4,
  output logic [SUM_W-1:0]  sum1,
  output logic [SUM_W-1:0]  sum2,
  output logic [SUM_W-1:0]  sum3,
  output logic [SUM_W-1:0]  sum4,
  output logic              div_en,
  output logic              busy,
  output logic              done,
`ifdef CEN_ACC_SAT_EN
  output logic              ovf,
`endif
  output logic [N_LOG2:0]   sample_cnt
);

  localparam int CNT_W = N_LOG2 + 1;
  localparam int FRM   = 1 << N_LOG2;

  state_t state, nxt_state;
  logic   clr, xfer, last;

  logic [DATA_W-1:0] xv [4];
  logic [SUM_W-1:0]  sv [4];

  assign in_ready = (state == ACCUM);
  assign div_en   = (state == PRESENT);
  assign done     = (state == FINISH);
  assign busy     = (state == ACCUM) || (state == PRESENT);

  assign clr  = (state == IDLE) && start;
  assign xfer = in_valid && in_ready;
  assign last = xfer && (sample_cnt == CNT_W'(FRM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (start) nxt_state = ACCUM;
      ACCUM:   if (last)  nxt_state = PRESENT;
      PRESENT: nxt_state = FINISH;
      FINISH:  nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else begin
      unique case (1'b1)
        clr:     sample_cnt <= '0;
        xfer:    sample_cnt <= sample_cnt + 1'b1;
        default: sample_cnt <= sample_cnt;
      endcase
    end
  end

  assign xv[0] = x1;
  assign xv[1] = x2;
  assign xv[2] = x3;
  assign xv[3] = x4;

`ifdef CEN_ACC_SAT_EN
  logic [3:0] sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (clr)  ovf <= 1'b0;
    else if (|sat) ovf <= 1'b1;
  end
`endif

  for (genvar k = 0; k < 4; k++) begin : g_lane
    cen_acc_lane #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .add_en (xfer),
      .x      (xv[k]),
`ifdef CEN_ACC_SAT_EN
      .sat    (sat[k]),
`endif
      .sum    (sv[k])
    );
  end

  assign sum1 = sv[0];
  assign sum2 = sv[1];
  assign sum3 = sv[2];
  assign sum4 = sv[3];

endmodule

// File: tb/tb_cen_accumulator.sv
// Self-checking bench for cen_accumulator (table + random frames).
// Build with CEN_ACC_SAT_EN to exercise saturation at SUM_W=38.
module tb_cen_accumulator;

  localparam int DW = 32;
  localparam int NL = 7;
  localparam int FL = 128;
`ifdef CEN_ACC_SAT_EN
  localparam int SW = 38;
  localparam bit SAT = 1'b1;
`else
  localparam int SW = 40;
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXS = (longint'(1) << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready;
  logic [DW-1:0] x1, x2, x3, x4;
  logic [SW-1:0] sum1, sum2, sum3, sum4;
  logic          div_en, busy, done;
  logic [NL:0]   sample_cnt;
`ifdef CEN_ACC_SAT_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cen_accumulator #(
    .DATA_W (DW),
    .SUM_W  (SW),
    .N_LOG2 (NL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .x4         (x4),
    .sum1       (sum1),
    .sum2       (sum2),
    .sum3       (sum3),
    .sum4       (sum4),
    .div_en     (div_en),
    .busy       (busy),
    .done       (done),
`ifdef CEN_ACC_SAT_EN
    .ovf        (ovf),
`endif
    .sample_cnt (sample_cnt)
  );

  typedef struct {
    int     kind;
    bit     smid;
    bit     sfin;
    longint e0, e1, e2, e3;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint fix(input longint t);
    if (SAT) return (t > MAXS) ? MAXS : t;
    return t & MAXS;
  endfunction

  function automatic longint sumk(input int k);
    case (k)
      0: return longint'(sum1);
      1: return longint'(sum2);
      2: return longint'(sum3);
      default: return longint'(sum4);
    endcase
  endfunction

  task automatic run_frame(input vec_t v, output longint ex [4]);
    longint        tot [4];
    logic [DW-1:0] xs [4];
    int            acc, cyc;
    bit            early, rdy, vld;
    // in_valid is high in the start cycle; it must not be counted
    start = 1'b1; in_valid = 1'b1;
    x1 = 7; x2 = 7; x3 = 7; x4 = 7;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    chk("start_cnt", sample_cnt, 0);
    chk("start_sum1", sum1, 0);
    chk("start_sum4", sum4, 0);
`ifdef CEN_ACC_SAT_EN
    chk("start_ovf", ovf, 0);
`endif
    for (int k = 0; k < 4; k++) tot[k] = 0;
    acc = 0; cyc = 0; early = 0;
    while (acc < FL && cyc < 1000) begin
      case (v.kind)
        1: vld = (cyc % 2 == 0);
        5: vld = 1'($urandom_range(0, 1));
        default: vld = 1'b1;
      endcase
      for (int k = 0; k < 4; k++) begin
        case (v.kind)
          0: xs[k] = (k == 0) ? 1 : (k == 1) ? 2 :
                     (k == 2) ? 100 : 32'hFFFF_FFFF;
          1: xs[k] = vld ? DW'(acc) : $urandom;
          2: xs[k] = 3;
          3: xs[k] = 5;
          4: xs[k] = 32'hFFFF_FFFF;
          default: xs[k] = $urandom;
        endcase
      end
      x1 = xs[0]; x2 = xs[1]; x3 = xs[2]; x4 = xs[3];
      in_valid = vld;
      start = v.smid && (acc == 50);
      rdy = in_ready;
      step();
      if (vld && rdy) begin
        acc++;
        for (int k = 0; k < 4; k++) tot[k] += longint'(xs[k]);
      end
      if (acc < FL && (div_en || done || !busy)) early = 1'b1;
      if (v.smid && acc == 51 && sample_cnt != 51) early = 1'b1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("frame_accepted", acc, FL);
    chk("no_early_div_en", early, 0);
    if (v.kind == 5) begin
      for (int k = 0; k < 4; k++) ex[k] = fix(tot[k]);
    end else begin
      ex[0] = fix(v.e0); ex[1] = fix(v.e1);
      ex[2] = fix(v.e2); ex[3] = fix(v.e3);
    end
    chk("pres_div_en", div_en, 1);
    chk("pres_done", done, 0);
    chk("pres_ready", in_ready, 0);
    chk("pres_busy", busy, 1);
    chk("pres_cnt", sample_cnt, FL);
    for (int k = 0; k < 4; k++) chk($sformatf("pres_sum%0d", k + 1), sumk(k), ex[k]);
`ifdef CEN_ACC_SAT_EN
    chk("pres_ovf", ovf, (tot[0] > MAXS || tot[1] > MAXS ||
                          tot[2] > MAXS || tot[3] > MAXS));
`endif
    start = v.sfin;
    step();
    chk("fin_done", done, 1);
    chk("fin_div_en", div_en, 0);
    chk("fin_busy", busy, 0);
    chk("fin_sum1", sum1, ex[0]);
    step();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", in_ready, 0);
    chk("idle_sum4", sum4, ex[3]);
    if (v.sfin) begin
      step();
      chk("fin_start_ignored", busy, 0);
      chk("fin_start_sum2", sum2, ex[1]);
    end
  endtask

  vec_t   tbl [7];
  longint ex [4];
  bit     spur;

  initial begin
    tbl[0] = '{0, 0, 1, 128, 256, 12800, 64'h7F_FFFF_FF80};
    tbl[1] = '{1, 1, 0, 8128, 8128, 8128, 8128};
    tbl[2] = '{2, 0, 0, 384, 384, 384, 384};
    tbl[3] = '{3, 0, 0, 640, 640, 640, 640};
    tbl[4] = '{4, 0, 0, 64'h7F_FFFF_FF80, 64'h7F_FFFF_FF80,
               64'h7F_FFFF_FF80, 64'h7F_FFFF_FF80};
    tbl[5] = '{5, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{5, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; x4 = '0;
    #12;
    chk("rst_sum1", sum1, 0);
    chk("rst_sum4", sum4, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
`ifdef CEN_ACC_SAT_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; x1 = 9;
    step();
    chk("idle_valid_ignored", sample_cnt, 0);
    in_valid = 1'b0;

    run_frame(tbl[0], ex);
    spur = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (div_en || done || busy) spur = 1'b1;
    end
    chk("hold_quiet", spur, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("hold_sum%0d", k + 1), sumk(k), ex[k]);

    run_frame(tbl[1], ex);

    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    x1 = 9; x2 = 9; x3 = 9; x4 = 9;
    for (int i = 0; i < 64; i++) step();
    chk("mid_cnt", sample_cnt, 64);
    chk("mid_sum1", sum1, 576);
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("mid_rst_sum1", sum1, 0);
    chk("mid_rst_sum3", sum3, 0);
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_div_en", div_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (div_en || done || busy) spur = 1'b1;
    end
    chk("post_rst_quiet", spur, 0);

    for (int i = 2; i < 7; i++) run_frame(tbl[i], ex);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
